// File: rtl/awg_cmd_pkg.sv
// Shared constants, FSM state type and byte-classification helpers for the
// AWG command parser.
package awg_cmd_pkg;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] KEY_W       = 8'h57;
   localparam logic [7:0] KEY_F       = 8'h46;
   localparam logic [7:0] KEY_A       = 8'h41;
   localparam logic [7:0] KEY_P       = 8'h50;
   localparam logic [7:0] KEY_R       = 8'h52;

   localparam logic [2:0] FLD_WAVE    = 3'd0;
   localparam logic [2:0] FLD_FREQ    = 3'd1;
   localparam logic [2:0] FLD_AMP     = 3'd2;
   localparam logic [2:0] FLD_PHASE   = 3'd3;
   localparam logic [2:0] FLD_RESTORE = 3'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      NUM     = 2'd1,
      DISCARD = 2'd2
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [7:0] to_upper(input logic [7:0] b);
      return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
   endfunction

   function automatic logic is_term(input logic [7:0] b);
      return (b == ASCII_CR) || (b == ASCII_LF);
   endfunction

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_0) && (b <= ASCII_9);
   endfunction

   // Returns {hit, field code}; hit=0 for anything that is not a key letter.
   function automatic logic [3:0] key_decode(input logic [7:0] b);
      case (to_upper(b))
         KEY_W:   return {1'b1, FLD_WAVE};
         KEY_F:   return {1'b1, FLD_FREQ};
         KEY_A:   return {1'b1, FLD_AMP};
         KEY_P:   return {1'b1, FLD_PHASE};
         KEY_R:   return {1'b1, FLD_RESTORE};
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/awg_cmd_parser_if.sv
// Received-byte stream from the UART into the command parser.
interface awg_cmd_parser_if;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (output rx_data, output rx_valid);
   modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/awg_dec_accum.sv
// Decimal digit accumulator with digit-count limit and sticky out-of-range flag.
module awg_dec_accum #(
   parameter int ACC_W      = 24,
   parameter int MAX_DIGITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             digit_stb,
   input  logic [3:0]       digit,
   input  logic [ACC_W-1:0] limit,
   output logic [ACC_W-1:0] acc,
   output logic             any_digit,
   output logic             bad
);
   localparam int CNT_W = $clog2(MAX_DIGITS + 1);

   logic [CNT_W-1:0] count;
   logic [ACC_W+3:0] prod;

   // Four guard bits hold acc*10+9 without wrapping, so overflow is always seen.
   assign prod      = {4'b0000, acc} * (ACC_W+4)'(10) + {{ACC_W{1'b0}}, digit};
   assign any_digit = (count != '0);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc   <= '0;
         count <= '0;
         bad   <= 1'b0;
      end else if (digit_stb && !bad) begin
         if (count >= CNT_W'(MAX_DIGITS) || prod > {4'b0000, limit}) begin
            bad <= 1'b1;
         end else begin
            acc   <= prod[ACC_W-1:0];
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/awg_cmd_parser.sv
// Line-framed ASCII command parser driving the AWG waveform settings.
module awg_cmd_parser
   import awg_cmd_pkg::*;
#(
   parameter int WAVE_W     = 3,
   parameter int FREQ_W     = 24,
   parameter int AMP_W      = 8,
   parameter int PHASE_W    = 12,
   parameter int MAX_DIGITS = 8,
   parameter int WAVE_DEF   = 0,
   parameter int FREQ_DEF   = 1,
   parameter int AMP_DEF    = 50,
   parameter int PHASE_DEF  = 0
) (
   input  logic               clk,
   input  logic               rst,
   awg_cmd_parser_if.slave    rx,
   output logic [WAVE_W-1:0]  wave,
   output logic [FREQ_W-1:0]  freq,
   output logic [AMP_W-1:0]   amp,
   output logic [PHASE_W-1:0] phase,
   output logic               update,
   output logic [2:0]         upd_field,
   output logic               err,
   output logic               busy
);
   localparam int ACC_W = max2(max2(FREQ_W, AMP_W), max2(PHASE_W, WAVE_W));
   localparam logic [ACC_W-1:0] WAVE_LIM  = ACC_W'((64'd1 << WAVE_W)  - 64'd1);
   localparam logic [ACC_W-1:0] FREQ_LIM  = ACC_W'((64'd1 << FREQ_W)  - 64'd1);
   localparam logic [ACC_W-1:0] AMP_LIM   = ACC_W'((64'd1 << AMP_W)   - 64'd1);
   localparam logic [ACC_W-1:0] PHASE_LIM = ACC_W'((64'd1 << PHASE_W) - 64'd1);

   state_t           state, state_nxt;
   logic [2:0]       fld;
   logic [3:0]       key;
   logic [ACC_W-1:0] acc, limit;
   logic             any_digit, bad;
   logic             clear, digit_stb, fld_ld, commit, err_nxt;

   assign key  = key_decode(rx.rx_data);
   assign busy = (state != IDLE);

   always_comb begin
      case (fld)
         FLD_WAVE: limit = WAVE_LIM;
         FLD_FREQ: limit = FREQ_LIM;
         FLD_AMP:  limit = AMP_LIM;
         default:  limit = PHASE_LIM;
      endcase
   end

   awg_dec_accum #(.ACC_W(ACC_W), .MAX_DIGITS(MAX_DIGITS)) u_accum (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .digit_stb (digit_stb),
      .digit     (rx.rx_data[3:0]),
      .limit     (limit),
      .acc       (acc),
      .any_digit (any_digit),
      .bad       (bad)
   );

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      digit_stb = 1'b0;
      fld_ld    = 1'b0;
      commit    = 1'b0;
      err_nxt   = 1'b0;
      if (rx.rx_valid) begin
         case (state)
            IDLE: begin
               if (key[3]) begin
                  fld_ld    = 1'b1;
                  clear     = 1'b1;
                  state_nxt = NUM;
               end else if (!(is_term(rx.rx_data) || rx.rx_data == ASCII_SPACE)) begin
                  err_nxt   = 1'b1;
                  state_nxt = DISCARD;
               end
            end
            NUM: begin
               if (is_digit(rx.rx_data)) begin
                  // Restore takes no argument, so a digit after R is rejected at once.
                  if (fld == FLD_RESTORE) begin
                     err_nxt   = 1'b1;
                     state_nxt = DISCARD;
                  end else begin
                     digit_stb = 1'b1;
                  end
               end else if (is_term(rx.rx_data)) begin
                  if (fld == FLD_RESTORE ? !any_digit : (!bad && any_digit))
                     commit = 1'b1;
                  else
                     err_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = DISCARD;
               end
            end
            DISCARD: begin
               if (is_term(rx.rx_data))
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fld       <= FLD_WAVE;
         wave      <= WAVE_W'(WAVE_DEF);
         freq      <= FREQ_W'(FREQ_DEF);
         amp       <= AMP_W'(AMP_DEF);
         phase     <= PHASE_W'(PHASE_DEF);
         update    <= 1'b0;
         err       <= 1'b0;
         upd_field <= FLD_WAVE;
      end else begin
         state  <= state_nxt;
         update <= commit;
         err    <= err_nxt;
         if (fld_ld)
            fld <= key[2:0];
         if (commit) begin
            upd_field <= fld;
            case (fld)
               FLD_WAVE:  wave  <= acc[WAVE_W-1:0];
               FLD_FREQ:  freq  <= acc[FREQ_W-1:0];
               FLD_AMP:   amp   <= acc[AMP_W-1:0];
               FLD_PHASE: phase <= acc[PHASE_W-1:0];
               default: begin
                  wave  <= WAVE_W'(WAVE_DEF);
                  freq  <= FREQ_W'(FREQ_DEF);
                  amp   <= AMP_W'(AMP_DEF);
                  phase <= PHASE_W'(PHASE_DEF);
               end
            endcase
         end
      end
   end

endmodule
